// File: rtl/params_pkg.sv
// Shared widths and the access-size encoding used by the processor-side memory path.
package params_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic {
        BYTE = 1'b0,
        WORD = 1'b1
    } access_size_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Request/response bus between the arbiter (master) and the fixed-latency memory (slave).
interface mem_req_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = params_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = params_pkg::DATA_WIDTH
);

    logic                       rd_req_valid;
    logic                       wr_req_valid;
    logic                       req_is_instr;
    logic [ADDR_WIDTH-1:0]      address;
    logic [DATA_WIDTH-1:0]      wr_data;
    params_pkg::access_size_t   access_size;
    logic                       data_valid;
    logic                       data_is_instr;
    logic [DATA_WIDTH-1:0]      data;

    modport master (
        output rd_req_valid, wr_req_valid, req_is_instr, address, wr_data, access_size,
        input  data_valid, data_is_instr, data
    );

    modport slave (
        input  rd_req_valid, wr_req_valid, req_is_instr, address, wr_data, access_size,
        output data_valid, data_is_instr, data
    );

endinterface

// File: rtl/mem_req_arbiter.sv
// Arbitrates instruction-fetch and data-port requests onto one memory bus, tracks one
// outstanding read per client and polices timeouts and spurious responses.
module mem_req_arbiter
    import params_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = params_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = params_pkg::DATA_WIDTH,
    parameter int unsigned MEM_LATENCY = 10,
    parameter int unsigned TIMEOUT     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  if_req_valid_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_req_ready_o,
    output logic                  if_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] if_rsp_data_o,

    input  logic                  dp_req_valid_i,
    input  logic                  dp_req_wr_i,
    input  logic [ADDR_WIDTH-1:0] dp_addr_i,
    input  logic [DATA_WIDTH-1:0] dp_wr_data_i,
    input  access_size_t          dp_access_size_i,
    output logic                  dp_req_ready_o,
    output logic                  dp_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] dp_rsp_data_o,

    mem_req_arbiter_if.master     mem,

    output logic [1:0]            err_o
);

    localparam int unsigned DRAIN_W = $clog2(MEM_LATENCY + 2);
    localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } client_state_t;

    client_state_t        if_state, if_state_n;
    client_state_t        dp_state, dp_state_n;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [TO_W-1:0]      if_to_cnt, dp_to_cnt;
    logic                 rr_dp, rr_dp_n;

    logic drain_done;
    logic if_elig, dp_elig, if_grant, dp_grant;
    logic rsp_hit, if_rsp_fire, dp_rsp_fire, spurious;
    logic if_timeout, dp_timeout;

    always_comb begin
        if_state_n  = if_state;
        dp_state_n  = dp_state;
        rr_dp_n     = rr_dp;

        drain_done  = (drain_cnt == '0);
        if_elig     = drain_done && if_req_valid_i && (if_state == S_IDLE);
        dp_elig     = drain_done && dp_req_valid_i && (dp_state == S_IDLE);
        if_grant    = if_elig && (!dp_elig || !rr_dp);
        dp_grant    = dp_elig && (!if_elig || rr_dp);
        if (if_elig && dp_elig) begin
            rr_dp_n = !rr_dp;
        end

        // Responses during drain belong to reads issued before reset: ignore them entirely.
        rsp_hit     = drain_done && mem.data_valid;
        if_rsp_fire = rsp_hit && mem.data_is_instr && (if_state == S_WAIT);
        dp_rsp_fire = rsp_hit && !mem.data_is_instr && (dp_state == S_WAIT);
        spurious    = rsp_hit && !if_rsp_fire && !dp_rsp_fire;

        if_timeout  = (if_state == S_WAIT) && (if_to_cnt == TO_W'(TIMEOUT - 1)) && !if_rsp_fire;
        dp_timeout  = (dp_state == S_WAIT) && (dp_to_cnt == TO_W'(TIMEOUT - 1)) && !dp_rsp_fire;

        case (if_state)
            S_IDLE:  if (if_grant) if_state_n = S_WAIT;
            S_WAIT:  if (if_rsp_fire || if_timeout) if_state_n = S_IDLE;
            default: if_state_n = S_IDLE;
        endcase

        case (dp_state)
            S_IDLE:  if (dp_grant && !dp_req_wr_i) dp_state_n = S_WAIT;
            S_WAIT:  if (dp_rsp_fire || dp_timeout) dp_state_n = S_IDLE;
            default: dp_state_n = S_IDLE;
        endcase
    end

    assign if_req_ready_o = if_grant;
    assign dp_req_ready_o = dp_grant;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_state          <= S_IDLE;
            dp_state          <= S_IDLE;
            rr_dp             <= 1'b1;
            drain_cnt         <= DRAIN_W'(MEM_LATENCY + 1);
            if_to_cnt         <= '0;
            dp_to_cnt         <= '0;
            mem.rd_req_valid  <= 1'b0;
            mem.wr_req_valid  <= 1'b0;
            mem.req_is_instr  <= 1'b0;
            mem.address       <= '0;
            mem.wr_data       <= '0;
            mem.access_size   <= BYTE;
            if_rsp_valid_o    <= 1'b0;
            if_rsp_data_o     <= '0;
            dp_rsp_valid_o    <= 1'b0;
            dp_rsp_data_o     <= '0;
            err_o             <= '0;
        end else begin
            if_state <= if_state_n;
            dp_state <= dp_state_n;
            rr_dp    <= rr_dp_n;

            if (!drain_done) begin
                drain_cnt <= drain_cnt - 1'b1;
            end

            // Counters sit at zero while idle, so they start from zero on entry to WAIT.
            if_to_cnt <= (if_state == S_WAIT) ? if_to_cnt + 1'b1 : '0;
            dp_to_cnt <= (dp_state == S_WAIT) ? dp_to_cnt + 1'b1 : '0;

            mem.rd_req_valid <= 1'b0;
            mem.wr_req_valid <= 1'b0;
            mem.req_is_instr <= 1'b0;
            mem.address      <= '0;
            mem.wr_data      <= '0;
            mem.access_size  <= BYTE;
            if (if_grant) begin
                mem.rd_req_valid <= 1'b1;
                mem.req_is_instr <= 1'b1;
                mem.address      <= if_addr_i;
                mem.access_size  <= WORD;
            end else if (dp_grant) begin
                mem.rd_req_valid <= !dp_req_wr_i;
                mem.wr_req_valid <= dp_req_wr_i;
                mem.address      <= dp_addr_i;
                mem.wr_data      <= dp_wr_data_i;
                mem.access_size  <= dp_access_size_i;
            end

            if_rsp_valid_o <= if_rsp_fire;
            dp_rsp_valid_o <= dp_rsp_fire;
            if (if_rsp_fire) begin
                if_rsp_data_o <= mem.data;
            end
            if (dp_rsp_fire) begin
                dp_rsp_data_o <= mem.data;
            end

            err_o <= err_o | {spurious, if_timeout || dp_timeout};
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomised and directed bench for mem_req_arbiter with a byte-array memory model and
// a cycle-level scoreboard of grants, memory requests, responses and error flags.
module tb_mem_req_arbiter;
    import params_pkg::*;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int          LAT    = 10;
    localparam int          TO     = 32;
    localparam int unsigned MAPPED = 'h300;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          if_req_valid_i;
    logic [AW-1:0] if_addr_i;
    logic          if_req_ready_o, if_rsp_valid_o;
    logic [DW-1:0] if_rsp_data_o;
    logic          dp_req_valid_i, dp_req_wr_i;
    logic [AW-1:0] dp_addr_i;
    logic [DW-1:0] dp_wr_data_i;
    access_size_t  dp_access_size_i;
    logic          dp_req_ready_o, dp_rsp_valid_o;
    logic [DW-1:0] dp_rsp_data_o;
    logic [1:0]    err_o;

    mem_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

    mem_req_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_valid_i(if_req_valid_i), .if_addr_i(if_addr_i),
        .if_req_ready_o(if_req_ready_o), .if_rsp_valid_o(if_rsp_valid_o),
        .if_rsp_data_o(if_rsp_data_o),
        .dp_req_valid_i(dp_req_valid_i), .dp_req_wr_i(dp_req_wr_i), .dp_addr_i(dp_addr_i),
        .dp_wr_data_i(dp_wr_data_i), .dp_access_size_i(dp_access_size_i),
        .dp_req_ready_o(dp_req_ready_o), .dp_rsp_valid_o(dp_rsp_valid_o),
        .dp_rsp_data_o(dp_rsp_data_o),
        .mem(mem_bus),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Memory contents: mem_arr is the memory model's own storage, ref_arr is the reference.
    logic [7:0] mem_arr [1024];
    logic [7:0] ref_arr [1024];

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a, input access_size_t s);
        int unsigned i = int'(a[9:0]);
        if (s == BYTE) return {24'h0, ref_arr[i]};
        i = i & ~32'd3;
        return {ref_arr[i+3], ref_arr[i+2], ref_arr[i+1], ref_arr[i]};
    endfunction

    function automatic void ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input access_size_t s);
        int unsigned i = int'(a[9:0]);
        if (a >= MAPPED) return;
        if (s == BYTE) begin
            ref_arr[i] = d[7:0];
        end else begin
            i = i & ~32'd3;
            for (int unsigned k = 0; k < 4; k++) ref_arr[i+k] = d[8*k +: 8];
        end
    endfunction

    // Memory model: fixed latency, little-endian, reads above MAPPED never answer.
    typedef struct { int due; logic instr; logic [DW-1:0] data; } mresp_t;
    mresp_t mem_pend[$];
    logic   spur_inject = 1'b0;
    logic   spur_instr  = 1'b0;

    always @(negedge clk) begin
        mresp_t m;
        int unsigned i;
        #1;
        i = int'(mem_bus.address[9:0]);
        if (mem_bus.wr_req_valid && mem_bus.address < MAPPED) begin
            if (mem_bus.access_size == BYTE) begin
                mem_arr[i] = mem_bus.wr_data[7:0];
            end else begin
                i = i & ~32'd3;
                for (int unsigned k = 0; k < 4; k++) mem_arr[i+k] = mem_bus.wr_data[8*k +: 8];
            end
        end
        if (mem_bus.rd_req_valid && mem_bus.address < MAPPED) begin
            m.due   = cyc + LAT;
            m.instr = mem_bus.req_is_instr;
            if (mem_bus.access_size == BYTE) begin
                m.data = {24'h0, mem_arr[i]};
            end else begin
                i = i & ~32'd3;
                m.data = {mem_arr[i+3], mem_arr[i+2], mem_arr[i+1], mem_arr[i]};
            end
            mem_pend.push_back(m);
        end
        if (mem_pend.size() > 0 && mem_pend[0].due == cyc) begin
            m = mem_pend.pop_front();
            mem_bus.data_valid    = 1'b1;
            mem_bus.data_is_instr = m.instr;
            mem_bus.data          = m.data;
        end else if (spur_inject) begin
            mem_bus.data_valid    = 1'b1;
            mem_bus.data_is_instr = spur_instr;
            mem_bus.data          = 32'h5A5A_5A5A;
        end else begin
            mem_bus.data_valid    = 1'b0;
            mem_bus.data_is_instr = 1'b0;
            mem_bus.data          = '0;
        end
    end

    // Scoreboard: expected events keyed by the cycle in which they must appear.
    typedef struct { int due; logic [DW-1:0] data; } rsp_t;
    typedef struct {
        int due; logic rd, wr, instr; logic [AW-1:0] addr; logic [DW-1:0] data; access_size_t size;
    } req_t;
    rsp_t if_q[$], dp_q[$];
    req_t req_q[$];

    logic       armed = 1'b0;
    logic       ptr_dp = 1'b1;
    logic [1:0] exp_err = 2'b00;
    int drain_end = 1 << 30;
    int if_acc = -100, if_free = 0, if_to_due = -1;
    int dp_acc = -100, dp_free = 0, dp_to_due = -1;
    int spur_vis = -1;

    always @(negedge clk) begin
        logic if_el, dp_el, if_win, dp_win, exp_v, busy;
        req_t r;
        rsp_t e;
        #2;
        if (armed) begin
            if (if_to_due == cyc || dp_to_due == cyc) exp_err[0] = 1'b1;
            if (spur_vis == cyc) exp_err[1] = 1'b1;
            chk("err_o", err_o, exp_err);

            if_el  = if_req_valid_i && cyc >= drain_end && cyc >= if_free;
            dp_el  = dp_req_valid_i && cyc >= drain_end && cyc >= dp_free;
            if_win = if_el && (!dp_el || !ptr_dp);
            dp_win = dp_el && (!if_el || ptr_dp);
            if (if_el && dp_el) ptr_dp = !ptr_dp;
            chk("if_req_ready_o", if_req_ready_o, if_win);
            chk("dp_req_ready_o", dp_req_ready_o, dp_win);

            exp_v = req_q.size() > 0 && req_q[0].due == cyc;
            chk("mem_rd_wr_valid", {mem_bus.rd_req_valid, mem_bus.wr_req_valid},
                exp_v ? {req_q[0].rd, req_q[0].wr} : 2'b00);
            if (exp_v) begin
                r = req_q.pop_front();
                chk("mem_address_o", mem_bus.address, r.addr);
                chk("mem_req_is_instr_o", mem_bus.req_is_instr, r.instr);
                chk("mem_access_size_o", mem_bus.access_size, r.size);
                if (r.wr) chk("mem_wr_data_o", mem_bus.wr_data, r.data);
            end

            exp_v = if_q.size() > 0 && if_q[0].due == cyc;
            chk("if_rsp_valid_o", if_rsp_valid_o, exp_v);
            if (exp_v) begin
                e = if_q.pop_front();
                chk("if_rsp_data_o", if_rsp_data_o, e.data);
            end
            exp_v = dp_q.size() > 0 && dp_q[0].due == cyc;
            chk("dp_rsp_valid_o", dp_rsp_valid_o, exp_v);
            if (exp_v) begin
                e = dp_q.pop_front();
                chk("dp_rsp_data_o", dp_rsp_data_o, e.data);
            end

            if (mem_bus.data_valid && cyc >= drain_end) begin
                busy = mem_bus.data_is_instr ? (if_acc < cyc && cyc < if_free)
                                             : (dp_acc < cyc && cyc < dp_free);
                if (!busy) spur_vis = cyc + 1;
            end

            if (if_win) begin
                req_q.push_back('{cyc + 1, 1'b1, 1'b0, 1'b1, if_addr_i, '0, WORD});
                if_acc = cyc;
                if (if_addr_i < MAPPED) begin
                    if_q.push_back('{cyc + LAT + 2, ref_read(if_addr_i, WORD)});
                    if_free = cyc + LAT + 2;
                end else begin
                    if_free   = cyc + TO + 1;
                    if_to_due = cyc + TO + 1;
                end
            end
            if (dp_win) begin
                req_q.push_back('{cyc + 1, !dp_req_wr_i, dp_req_wr_i, 1'b0, dp_addr_i,
                                  dp_wr_data_i, dp_access_size_i});
                if (dp_req_wr_i) begin
                    ref_write(dp_addr_i, dp_wr_data_i, dp_access_size_i);
                end else begin
                    dp_acc = cyc;
                    if (dp_addr_i < MAPPED) begin
                        dp_q.push_back('{cyc + LAT + 2, ref_read(dp_addr_i, dp_access_size_i)});
                        dp_free = cyc + LAT + 2;
                    end else begin
                        dp_free   = cyc + TO + 1;
                        dp_to_due = cyc + TO + 1;
                    end
                end
            end
        end
        if (rst_i) begin
            armed     = 1'b1;
            drain_end = cyc + LAT + 2;
            ptr_dp    = 1'b1;
            exp_err   = 2'b00;
            if_acc = -100; if_free = 0; if_to_due = -1;
            dp_acc = -100; dp_free = 0; dp_to_due = -1;
            spur_vis = -1;
            if_q.delete();
            dp_q.delete();
            req_q.delete();
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic wait_accept(output int if_at, output int dp_at);
        int  n = 0;
        logic ia, da;
        if_at = -1;
        dp_at = -1;
        while ((if_req_valid_i || dp_req_valid_i) && n < 200) begin
            #1;
            ia = if_req_valid_i && if_req_ready_o;
            da = dp_req_valid_i && dp_req_ready_o;
            if (ia) if_at = cyc;
            if (da) dp_at = cyc;
            @(negedge clk);
            n++;
            if (ia) if_req_valid_i = 1'b0;
            if (da) dp_req_valid_i = 1'b0;
        end
        chk("accept_within_bound", n < 200, 1'b1);
        if_req_valid_i = 1'b0;
        dp_req_valid_i = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr(input logic word_aligned);
        logic [AW-1:0] a;
        if ($urandom_range(0, 15) == 0) a = AW'(MAPPED + $urandom_range(0, 'hFF));
        else a = AW'($urandom_range(0, MAPPED - 1));
        if (word_aligned) a[1:0] = 2'b00;
        return a;
    endfunction

    initial begin
        int ia, da, rel, st_at, ld_at, n;
        logic [7:0] b;
        for (int i = 0; i < 1024; i++) begin
            b = 8'($urandom);
            mem_arr[i] = b;
            ref_arr[i] = b;
        end
        {mem_arr[7], mem_arr[6], mem_arr[5], mem_arr[4]} = 32'h0004_46F1;
        {ref_arr[7], ref_arr[6], ref_arr[5], ref_arr[4]} = 32'h0004_46F1;

        rst_i = 1'b1;
        dp_req_wr_i = 1'b0; dp_wr_data_i = '0; dp_access_size_i = WORD;
        // Contention straight out of reset: both clients wait through the drain window.
        if_req_valid_i = 1'b1; if_addr_i = 32'h4;
        dp_req_valid_i = 1'b1; dp_addr_i = 32'h8;
        step(2);
        rst_i = 1'b0;
        rel = cyc;
        wait_accept(ia, da);
        chk("drain_then_dp_grant", da - rel, LAT + 1);
        chk("if_granted_after_dp", ia - da, 1);
        step(15);
        chk("single_fetch_data", if_rsp_data_o, 32'h0004_46F1);

        dp_req_valid_i = 1'b1; dp_req_wr_i = 1'b1; dp_addr_i = 32'h40;
        dp_wr_data_i = 32'hDEAD_BEEF; dp_access_size_i = WORD;
        wait_accept(ia, st_at);
        dp_req_valid_i = 1'b1; dp_req_wr_i = 1'b0; dp_addr_i = 32'h41;
        dp_access_size_i = BYTE;
        wait_accept(ia, ld_at);
        chk("store_then_load_gap", ld_at - st_at, 1);
        step(15);
        chk("byte_load_data", dp_rsp_data_o, 32'h0000_00BE);

        if_req_valid_i = 1'b1; if_addr_i = 32'h300;
        wait_accept(ia, da);
        n = 0;
        while (err_o[0] == 1'b0 && n < 100) begin
            step(1);
            n++;
        end
        chk("timeout_latency", cyc - ia, TO + 1);
        chk("timeout_err", err_o, 2'b01);
        step(3);

        dp_req_valid_i = 1'b1; dp_req_wr_i = 1'b0; dp_addr_i = 32'h10; dp_access_size_i = WORD;
        wait_accept(ia, da);
        step(4);
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        rel = cyc;
        if_req_valid_i = 1'b1; if_addr_i = 32'h8;
        wait_accept(ia, da);
        chk("drain_after_mid_reset", ia - rel, LAT + 1);
        step(15);
        chk("err_after_mid_reset", err_o, 2'b00);

        spur_inject = 1'b1; spur_instr = 1'b1;
        step(1);
        spur_inject = 1'b0;
        step(1);
        chk("spurious_err", err_o, 2'b10);
        step(2);

        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if_req_valid_i   = ($urandom_range(0, 2) != 0);
            if_addr_i        = rand_addr(1'b1);
            dp_req_valid_i   = ($urandom_range(0, 2) != 0);
            dp_req_wr_i      = 1'($urandom_range(0, 1));
            dp_addr_i        = rand_addr(1'b0);
            dp_wr_data_i     = $urandom;
            dp_access_size_i = access_size_t'($urandom_range(0, 1));
            step(1);
        end
        if_req_valid_i = 1'b0;
        dp_req_valid_i = 1'b0;
        step(TO + 10);
        chk("if_rsp_outstanding", if_q.size(), 0);
        chk("dp_rsp_outstanding", dp_q.size(), 0);
        chk("mem_req_outstanding", req_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Processor-side initiator for the fixed-latency pipelined byte-addressed memory.
- Accepts requests from two clients: the instruction-fetch port (IF, read-only, WORD) and the data port (DP, load/store, BYTE/WORD).
- Arbitrates the two clients onto the single memory request interface and tracks one outstanding read per client.
- Routes responses back by mem_data_is_instr_i, and polices timeouts and spurious responses.

Parameters:
- ADDR_WIDTH, params_pkg::ADDR_WIDTH, address width.
- DATA_WIDTH, params_pkg::DATA_WIDTH, data width (32).
- MEM_LATENCY, 10, cycles from memory request to mem_data_valid_i.
- TIMEOUT, 32, cycles in WAIT before a read is abandoned (must be > MEM_LATENCY+1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- if_req_valid_i  in  1  fetch request.
- if_addr_i  in  ADDR_WIDTH  fetch byte address.
- if_req_ready_o  out  1  fetch request accepted this cycle when high with valid.
- if_rsp_valid_o  out  1  fetch data valid (1-cycle pulse).
- if_rsp_data_o  out  DATA_WIDTH  fetched word.
- dp_req_valid_i  in  1  data request.
- dp_req_wr_i  in  1  1 = store, 0 = load.
- dp_addr_i  in  ADDR_WIDTH  data byte address.
- dp_wr_data_i  in  DATA_WIDTH  store data.
- dp_access_size_i  in  access_size_t  BYTE/WORD.
- dp_req_ready_o  out  1  data request accepted.
- dp_rsp_valid_o  out  1  load data valid (1-cycle pulse).
- dp_rsp_data_o  out  DATA_WIDTH  load data (BYTE already zero-extended by memory).
- mem_rd_req_valid_o  out  1  memory read request.
- mem_wr_req_valid_o  out  1  memory write request.
- mem_req_is_instr_o  out  1  1 for IF requests.
- mem_address_o  out  ADDR_WIDTH  request address.
- mem_wr_data_o  out  DATA_WIDTH  store data.
- mem_access_size_o  out  access_size_t  request size.
- mem_data_valid_i  in  1  memory response valid.
- mem_data_is_instr_i  in  1  response belongs to IF.
- mem_data_i  in  DATA_WIDTH  response data.
- err_o  out  2  sticky: [0] timeout, [1] spurious response.

Behaviour:
- Reset: rst_i sampled high at a clock edge clears everything.
  - All outputs go to 0 and err_o to 0.
  - Both client FSMs go to IDLE, the round-robin pointer points to DP, and the drain counter loads MEM_LATENCY+1.
- Drain: while the drain counter is nonzero:
  - both ready outputs are 0 and the counter decrements each cycle;
  - any mem_data_valid_i is dropped silently, with no rsp pulse and no err bit.
  - This flushes reads that were in flight before the reset.
- Per-client FSM, IDLE -> WAIT -> IDLE:
  - ready_o = drain done & FSM IDLE & arbitration won; it is combinational from the valid inputs and state.
  - An accepted read moves the client to WAIT. An accepted DP store stays IDLE (no response expected).
- Arbitration, one grant per cycle among eligible clients (valid & IDLE):
  - If both are eligible, the pointer's client wins and the pointer flips to the other client.
  - A single eligible client wins without moving the pointer.
- Request issue (registered): accept in cycle 0; mem_* outputs are driven for exactly cycle 1, then return to 0.
  - IF requests: rd=1, is_instr=1, size=WORD.
  - DP requests: rd = ~dp_req_wr_i, wr = dp_req_wr_i, is_instr=0, size and data from DP.
  - mem_rd_req_valid_o and mem_wr_req_valid_o are never both 1.
- Response: mem_data_valid_i is expected in cycle 1+MEM_LATENCY (cycle 11).
  - The target client is selected by mem_data_is_instr_i.
  - If the target is in WAIT: rsp_valid_o=1 and rsp_data_o=mem_data_i in the next cycle (cycle 12), and the FSM returns to IDLE.
  - The client may be accepted again in cycle 12 (not earlier).
  - rsp_data_o holds its value until the next response.
- Timeout: a per-client counter resets on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT: err_o[0] is set, the FSM returns to IDLE, and no rsp pulse is generated.
- Spurious: mem_data_valid_i outside drain, with the target client IDLE, is dropped and sets err_o[1].
- Simultaneous events:
  - A response and a timeout on the same cycle for the same client: the response wins, and err_o[0] is not set.
  - IF and DP responses cannot coincide; the memory has one response per cycle.
- err_o bits clear only on reset.

Test Plan:
- Single fetch: after drain, IF valid with addr 0x4; memory model returns 0x000446F1 -> if_rsp_valid_o pulses in cycle 12 with 0x000446F1; if_req_ready_o is 0 in cycles 1-11.
- Contention: IF and DP loads presented together in the first post-drain cycle -> DP granted (mem_req_is_instr_o=0 in cycle 1); IF granted next cycle; both responses are returned to the correct port one cycle apart.
- Store then byte load: DP WORD store 0xDEADBEEF to 0x40 (dp_req_ready_o high again the next cycle), then BYTE load 0x41 -> dp_rsp_data_o=0x000000BE; no rsp pulse for the store.
- Timeout: the memory model suppresses the IF response -> err_o=2'b01 exactly TIMEOUT cycles after entry to WAIT; if_req_ready_o returns to 1 the next cycle.
- Reset mid-read: rst_i high for 1 cycle at cycle 5 after a DP load -> the response at cycle 11 is dropped; err_o=0; ready stays 0 for MEM_LATENCY+1 cycles after reset.
- Spurious: inject mem_data_valid_i=1 with is_instr=1 while IF is IDLE -> err_o[1]=1 and if_rsp_valid_o stays 0.
